// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared definitions for the iterative IEEE-754 divider.
//   state_t  - divider FSM states
//   FLG_*    - bit positions inside the 5-bit exception flag vector
//   qnan()   - canonical quiet NaN pattern for a given exponent/fraction width
package fp_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        ROUND,
        DONE
    } state_t;

    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    // {0, all-ones exponent, fraction MSB set, rest zero}, right-aligned in 128 bits.
    function automatic logic [127:0] qnan(input int unsigned ew, input int unsigned mw);
        logic [127:0] v;
        v = '0;
        for (int unsigned i = 0; i < ew; i++) begin
            v[mw + i] = 1'b1;
        end
        v[mw - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// fp_div_round: combinational round-to-nearest-even, range check and packing
// for the iterative divider.
// Optional feature macro: FPDIV_FLAGS_EN (adds the flags output).
// Ports:
//   sign    in  1        result sign
//   exp_in  in  EW+2     signed biased exponent, quotient already in [1,2)
//   q       in  MW+3     quotient bits: hidden, fraction[MW], guard, round
//   sticky  in  1        final partial remainder is non-zero
//   res     out EW+MW+1  packed IEEE result
//   flags   out 5        {invalid, div_zero, overflow, underflow, inexact}
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int EW = 11,
    parameter int MW = 52
) (
    input  logic                 sign,
    input  logic signed [EW+1:0] exp_in,
    input  logic [MW+2:0]        q,
    input  logic                 sticky,
    output logic [EW+MW:0]       res
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [4:0]           flags
`endif
);

    logic          g_bit;
    logic          s_bit;
    logic          inc;
    logic          carry;
    logic [MW-1:0] frac_r;
    logic signed [EW+1:0] exp_r;
    logic          of;
    logic          uf;
    logic          unused_hidden;

    // The hidden bit is always 1 by construction and carries no information.
    assign unused_hidden = q[MW+2];

    assign g_bit = q[1];
    assign s_bit = q[0] | sticky;
    assign inc   = g_bit & (s_bit | q[2]);

    assign {carry, frac_r} = {1'b0, q[MW+1:2]} + {{MW{1'b0}}, inc};
    assign exp_r = exp_in + $signed({{(EW+1){1'b0}}, carry});

    assign uf = exp_r[EW+1] || (exp_r == '0);
    assign of = !exp_r[EW+1] && (exp_r[EW:0] >= (EW+1)'(2**EW - 1));

    always_comb begin
        res = {sign, exp_r[EW-1:0], frac_r};
        if (of) begin
            res = {sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (uf) begin
            res = {sign, {(EW+MW){1'b0}}};
        end
    end

`ifdef FPDIV_FLAGS_EN
    always_comb begin
        flags = '0;
        if (of) begin
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else if (uf) begin
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else begin
            flags[FLG_NX] = g_bit | s_bit;
        end
    end
`endif

endmodule

// File: rtl/fp_div_iter.sv
// fp_div_iter: sequential IEEE-754 divider a/b, radix-2 restoring, one
// quotient bit per cycle, round-to-nearest-even, subnormals flushed to zero.
// Optional feature macro: FPDIV_FLAGS_EN (adds out_flags and all flag logic).
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        idle, accepting operands
//   in_a       in   EW+MW+1  dividend
//   in_b       in   EW+MW+1  divisor
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        consumer accepts result
//   out_data   out  EW+MW+1  quotient
//   out_flags  out  5        {invalid, div_zero, overflow, underflow, inexact}
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EW = 11,
    parameter int MW = 52
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] in_a,
    input  logic [EW+MW:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] out_data
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [4:0]     out_flags
`endif
);

    localparam int W    = EW + MW + 1;
    localparam int BIAS = 2**(EW-1) - 1;
    localparam int CW   = $clog2(MW + 3);
    localparam logic [W-1:0]       QNAN   = W'(qnan(EW, MW));
    localparam logic signed [EW+1:0] BIAS_X = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] ONE_X  = (EW+2)'(1);

    state_t state, state_nxt;

    logic [W-1:0]         a_r, b_r;
    logic                 sign_r;
    logic signed [EW+1:0] exp_r;
    logic [MW+1:0]        rem_r;
    logic [MW:0]          mb_r;
    logic [MW+2:0]        q_r;
    logic [CW-1:0]        cnt_r;
    logic                 spec_r;
    logic [W-1:0]         spec_res_r;

    // operand fields
    logic          sa, sb, sign_q;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MW:0]   ma, mb;
    logic          ma_lt;
    logic signed [EW+1:0] e_diff, exp_init;
    logic [MW+1:0] rem_init;

    logic          spec;
    logic [W-1:0]  spec_res;

    logic          rem_ge;
    logic [MW+1:0] rem_sub, rem_nxt;
    logic [W-1:0]  rnd_res;

`ifdef FPDIV_FLAGS_EN
    logic [4:0] spec_flg, spec_flg_r, rnd_flg;
`endif

    assign sa = a_r[W-1];
    assign sb = b_r[W-1];
    assign ea = a_r[W-2:MW];
    assign eb = b_r[W-2:MW];
    assign fa = a_r[MW-1:0];
    assign fb = b_r[MW-1:0];
    assign sign_q = sa ^ sb;

    // Zero exponent covers both true zeros and subnormals (flush-to-zero).
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);

    assign ma     = {1'b1, fa};
    assign mb     = {1'b1, fb};
    assign ma_lt  = (ma < mb);
    assign e_diff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;
    // Pre-normalise so the quotient lands in [1,2) and the first bit is always 1.
    assign exp_init = ma_lt ? (e_diff - ONE_X) : e_diff;
    assign rem_init = ma_lt ? {ma, 1'b0} : {1'b0, ma};

    always_comb begin
        spec     = 1'b1;
        spec_res = '0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
        end else if (b_zero) begin
            spec_res = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero) begin
            spec_res = {sign_q, {(W-1){1'b0}}};
        end else if (a_inf) begin
            spec_res = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sign_q, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

`ifdef FPDIV_FLAGS_EN
    always_comb begin
        spec_flg = '0;
        if (!(a_nan || b_nan)) begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                spec_flg[FLG_NV] = 1'b1;
            end else if (b_zero) begin
                spec_flg[FLG_DZ] = 1'b1;
            end
        end
    end
`endif

    // Restoring step: subtract divisor when it fits, then shift.
    assign rem_ge  = (rem_r >= {1'b0, mb_r});
    assign rem_sub = rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r;
    assign rem_nxt = rem_sub << 1;

    fp_div_round #(
        .EW(EW),
        .MW(MW)
    ) u_round (
        .sign   (sign_r),
        .exp_in (exp_r),
        .q      (q_r),
        .sticky (rem_r != '0),
        .res    (rnd_res)
`ifdef FPDIV_FLAGS_EN
        ,
        .flags  (rnd_flg)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Specials also pass through ROUND so every result is published by the
    // same output register; this fixes the special-case latency at two cycles.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = PREP;
            end
            PREP:  state_nxt = spec ? ROUND : ITER;
            ITER:  if (cnt_r == '0) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            rem_r      <= '0;
            mb_r       <= '0;
            q_r        <= '0;
            cnt_r      <= '0;
            spec_r     <= 1'b0;
            spec_res_r <= '0;
            out_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= in_a;
                        b_r <= in_b;
                    end
                end
                PREP: begin
                    spec_r     <= spec;
                    spec_res_r <= spec_res;
                    sign_r     <= sign_q;
                    exp_r      <= exp_init;
                    rem_r      <= rem_init;
                    mb_r       <= mb;
                    q_r        <= '0;
                    cnt_r      <= CW'(MW + 2);
                end
                ITER: begin
                    q_r   <= {q_r[MW+1:0], rem_ge};
                    rem_r <= rem_nxt;
                    cnt_r <= cnt_r - 1'b1;
                end
                ROUND: begin
                    out_data <= spec_r ? spec_res_r : rnd_res;
                end
                default: ;
            endcase
        end
    end

`ifdef FPDIV_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_flg_r <= '0;
            out_flags  <= '0;
        end else begin
            if (state == PREP) spec_flg_r <= spec_flg;
            if (state == ROUND) out_flags <= spec_r ? spec_flg_r : rnd_flg;
        end
    end
`endif

endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;

    logic clk;
    logic rst_n;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_in_a, d_in_b, d_out_data;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_a, s_in_b, s_out_data;
`ifdef FPDIV_FLAGS_EN
    logic [4:0]  d_out_flags, s_out_flags;
`endif

    int total;
    int bad;

    fp_div_iter #(.EW(11), .MW(52)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_b(d_in_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data)
`ifdef FPDIV_FLAGS_EN
        , .out_flags(d_out_flags)
`endif
    );

    fp_div_iter #(.EW(8), .MW(23)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data)
`ifdef FPDIV_FLAGS_EN
        , .out_flags(s_out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation, returns result, flags and cycles from accept edge to out_valid.
    task automatic run_op(input bit s32, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] d, output logic [4:0] f, output int lat);
        int guard;
        guard = 0;
        f = '0;
        @(negedge clk);
        while (!(s32 ? s_in_ready : d_in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (s32) begin
            s_in_valid = 1'b1; s_in_a = a[31:0]; s_in_b = b[31:0];
        end else begin
            d_in_valid = 1'b1; d_in_a = a; d_in_b = b;
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
        lat = 0;
        while (!(s32 ? s_out_valid : d_out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        d = s32 ? {32'h0, s_out_data} : d_out_data;
`ifdef FPDIV_FLAGS_EN
        f = s32 ? s_out_flags : d_out_flags;
`endif
        if (s32) s_out_ready = 1'b1; else d_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        d_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin bad++;
            $display("FAIL reset64_hs got valid=%b ready=%b want valid=0 ready=1", d_out_valid, d_in_ready); end
        total++; if (d_out_data !== 64'h0) begin bad++;
            $display("FAIL reset64_data got=%h want=0", d_out_data); end
        total++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_out_data !== 32'h0) begin bad++;
            $display("FAIL reset32 got valid=%b ready=%b data=%h want 0/1/0", s_out_valid, s_in_ready, s_out_data); end
`ifdef FPDIV_FLAGS_EN
        total++; if (d_out_flags !== 5'h0 || s_out_flags !== 5'h0) begin bad++;
            $display("FAIL reset_flags got=%b/%b want=0", d_out_flags, s_out_flags); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin bad++;
            $display("FAIL post_reset got ready=%b valid=%b want 1/0", d_in_ready, d_out_valid); end
    endtask

    task automatic test_fp64_normal;
        logic [63:0] d; logic [4:0] f; int lat;
        run_op(1'b0, 64'h4018000000000000, 64'h4000000000000000, d, f, lat);
        total++; if (d !== 64'h4008000000000000) begin bad++;
            $display("FAIL div6_2 got=%h want=4008000000000000", d); end
        total++; if (lat !== 57) begin bad++;
            $display("FAIL div6_2_latency got=%0d want=57", lat); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00000) begin bad++;
            $display("FAIL div6_2_flags got=%b want=00000", f); end
`endif
        run_op(1'b0, 64'h3FF0000000000000, 64'h4008000000000000, d, f, lat);
        total++; if (d !== 64'h3FD5555555555555) begin bad++;
            $display("FAIL div1_3 got=%h want=3FD5555555555555", d); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00001) begin bad++;
            $display("FAIL div1_3_flags got=%b want=00001", f); end
`endif
    endtask

    task automatic test_specials;
        logic [63:0] d; logic [4:0] f; int lat;
        run_op(1'b0, 64'h0000000000000000, 64'h0000000000000000, d, f, lat);
        total++; if (d !== 64'h7FF8000000000000 || lat !== 2) begin bad++;
            $display("FAIL zero_zero got=%h lat=%0d want=7FF8000000000000 lat=2", d, lat); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b10000) begin bad++;
            $display("FAIL zero_zero_flags got=%b want=10000", f); end
`endif
        run_op(1'b0, 64'h3FF0000000000000, 64'h8000000000000000, d, f, lat);
        total++; if (d !== 64'hFFF0000000000000 || lat !== 2) begin bad++;
            $display("FAIL div_negzero got=%h lat=%0d want=FFF0000000000000 lat=2", d, lat); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b01000) begin bad++;
            $display("FAIL div_negzero_flags got=%b want=01000", f); end
`endif
        run_op(1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000, d, f, lat);
        total++; if (d !== 64'h7FF8000000000000 || lat !== 2) begin bad++;
            $display("FAIL nan_in got=%h lat=%0d want=7FF8000000000000 lat=2", d, lat); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00000) begin bad++;
            $display("FAIL nan_in_flags got=%b want=00000", f); end
`endif
    endtask

    task automatic test_range;
        logic [63:0] d; logic [4:0] f; int lat;
        run_op(1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, d, f, lat);
        total++; if (d !== 64'h7FF0000000000000) begin bad++;
            $display("FAIL overflow got=%h want=7FF0000000000000", d); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00101) begin bad++;
            $display("FAIL overflow_flags got=%b want=00101", f); end
`endif
        run_op(1'b0, 64'h0010000000000000, 64'h4000000000000000, d, f, lat);
        total++; if (d !== 64'h0000000000000000) begin bad++;
            $display("FAIL underflow got=%h want=0000000000000000", d); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00011) begin bad++;
            $display("FAIL underflow_flags got=%b want=00011", f); end
`endif
    endtask

    task automatic test_hold;
        logic [63:0] d; logic [4:0] f; int lat;
        int hold_bad;
        int guard;
        @(negedge clk);
        d_in_valid = 1'b1; d_in_a = 64'h4018000000000000; d_in_b = 64'h4000000000000000;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        guard = 0;
        while (!d_out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        total++; if (guard >= 200) begin bad++;
            $display("FAIL hold_wait got=timeout want=out_valid"); end
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_in_valid = (i % 2 == 0);
            d_in_a = 64'h3FF0000000000000; d_in_b = 64'h4008000000000000;
            @(posedge clk); #1;
            if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || d_out_data !== 64'h4008000000000000)
                hold_bad++;
        end
        total++; if (hold_bad != 0) begin bad++;
            $display("FAIL hold_stable got=%0d bad cycles (valid=%b ready=%b data=%h) want=0",
                     hold_bad, d_out_valid, d_in_ready, d_out_data); end
        // Pop with in_valid still high: the pop cycle must not accept.
        @(negedge clk);
        d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin bad++;
            $display("FAIL pop_no_accept got valid=%b ready=%b want 0/1", d_out_valid, d_in_ready); end
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        run_op(1'b0, 64'h3FF0000000000000, 64'h4008000000000000, d, f, lat);
        total++; if (d !== 64'h3FD5555555555555 || lat !== 57) begin bad++;
            $display("FAIL after_hold got=%h lat=%0d want=3FD5555555555555 lat=57", d, lat); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d; logic [4:0] f; int lat;
        @(negedge clk);
        d_in_valid = 1'b1; d_in_a = 64'h4018000000000000; d_in_b = 64'h4000000000000000;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (d_in_ready !== 1'b0) begin bad++;
            $display("FAIL busy_before_reset got ready=%b want 0", d_in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin bad++;
            $display("FAIL mid_reset got valid=%b ready=%b want 0/1", d_out_valid, d_in_ready); end
        @(negedge clk); rst_n = 1'b1;
        run_op(1'b0, 64'h4018000000000000, 64'h4000000000000000, d, f, lat);
        total++; if (d !== 64'h4008000000000000 || lat !== 57) begin bad++;
            $display("FAIL after_mid_reset got=%h lat=%0d want=4008000000000000 lat=57", d, lat); end
    endtask

    task automatic test_fp32;
        logic [63:0] d; logic [4:0] f; int lat;
        run_op(1'b1, 64'h40400000, 64'h3F800000, d, f, lat);
        total++; if (d[31:0] !== 32'h40400000) begin bad++;
            $display("FAIL fp32_3_1 got=%h want=40400000", d[31:0]); end
        total++; if (lat !== 28) begin bad++;
            $display("FAIL fp32_latency got=%0d want=28", lat); end
        run_op(1'b1, 64'h3F800000, 64'h40400000, d, f, lat);
        total++; if (d[31:0] !== 32'h3EAAAAAB) begin bad++;
            $display("FAIL fp32_1_3 got=%h want=3EAAAAAB", d[31:0]); end
`ifdef FPDIV_FLAGS_EN
        total++; if (f !== 5'b00001) begin bad++;
            $display("FAIL fp32_1_3_flags got=%b want=00001", f); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b0;
        test_reset;
        test_fp64_normal;
        test_specials;
        test_range;
        test_hold;
        test_reset_mid;
        test_fp32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
